audio_event_pio: RTL and testbench

AUDIO_EVENT_PIO -- requirements
Module: audio_event_pio

---
 rtl/audio_event_pio.sv | 116 +++++++++++
 tb/tb_audio_event_pio.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/audio_event_pio.sv
// rtl/audio_event_pio.sv - edge-capturing PIO with per-bit rise/fall enables, W1C capture and overrun, Avalon slave.
// Optional macro AUDIO_EVENT_PIO_SYNC_EN adds a second synchroniser flop ahead of the history stage.
module audio_event_pio #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] RISE_RESET = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] FALL_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sampled;
    logic [WIDTH-1:0] history;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] overrun;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] ovr_clr;
    logic [31:0]      read_value;
    logic             wr;
    logic             unused_writedata;

`ifdef AUDIO_EVENT_PIO_SYNC_EN
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta    <= '0;
            sampled <= '0;
        end else begin
            meta    <= in_port;
            sampled <= meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            sampled <= '0;
        end else begin
            sampled <= in_port;
        end
    end
`endif

    // History tracks the sampled value unconditionally so a late enable never sees a stale edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            history <= '0;
        end else begin
            history <= sampled;
        end
    end

    assign wr               = chipselect & ~write_n;
    assign unused_writedata = ^writedata;
    assign events           = (sampled & ~history & rise_en) | (~sampled & history & fall_en);
    assign cap_clr          = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    assign ovr_clr          = (wr && address == 3'd5) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_en      <= RISE_RESET;
            fall_en      <= FALL_RESET;
            irq_mask     <= '0;
            edge_capture <= '0;
            overrun      <= '0;
        end else begin
            if (wr && address == 3'd1) begin
                rise_en <= writedata[WIDTH-1:0];
            end
            if (wr && address == 3'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (wr && address == 3'd4) begin
                fall_en <= writedata[WIDTH-1:0];
            end
            // New events win over a same-cycle clear; a clear in that cycle suppresses overrun.
            edge_capture <= (edge_capture & ~cap_clr) | events;
            overrun      <= (overrun & ~ovr_clr) | (events & edge_capture & ~cap_clr);
        end
    end

    always_comb begin
        read_value = '0;
        case (address)
            3'd0:    read_value[WIDTH-1:0] = sampled;
            3'd1:    read_value[WIDTH-1:0] = rise_en;
            3'd2:    read_value[WIDTH-1:0] = irq_mask;
            3'd3:    read_value[WIDTH-1:0] = edge_capture;
            3'd4:    read_value[WIDTH-1:0] = fall_en;
            3'd5:    read_value[WIDTH-1:0] = overrun;
            default: read_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= read_value;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_audio_event_pio.sv
// tb/tb_audio_event_pio.sv - directed and randomized checks of audio_event_pio against a delay-line reference model.
module tb_audio_event_pio;

`ifdef AUDIO_EVENT_PIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  in_port = '0;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Reference model state: in_q holds in_port at the previous LAT edges, most recent first.
    logic [3:0]  in_q[$];
    logic [3:0]  m_rise, m_fall, m_mask, m_cap, m_ovr;
    logic [31:0] m_rd;
    logic        m_irq;

    audio_event_pio #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] inp, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [31:0] wd);
        logic [3:0] cur, old, ncap, novr;
        logic       ev, clr, oclr, wr;
        if (r) begin
            m_rd = '0; m_cap = '0; m_ovr = '0; m_mask = '0; m_rise = 4'hF; m_fall = 4'h0;
            in_q = {};
            repeat (LAT) in_q.push_back(4'h0);
        end else begin
            cur = in_q[LAT-2];
            old = in_q[LAT-1];
            case (a)
                3'd0: m_rd = {28'd0, cur};
                3'd1: m_rd = {28'd0, m_rise};
                3'd2: m_rd = {28'd0, m_mask};
                3'd3: m_rd = {28'd0, m_cap};
                3'd4: m_rd = {28'd0, m_fall};
                3'd5: m_rd = {28'd0, m_ovr};
                default: m_rd = '0;
            endcase
            wr = cs && !wn;
            for (int i = 0; i < 4; i++) begin
                ev   = (cur[i] && !old[i] && m_rise[i]) || (!cur[i] && old[i] && m_fall[i]);
                clr  = wr && (a == 3'd3) && wd[i];
                oclr = wr && (a == 3'd5) && wd[i];
                if (ev) ncap[i] = 1'b1;
                else if (clr) ncap[i] = 1'b0;
                else ncap[i] = m_cap[i];
                if (ev && m_cap[i] && !clr) novr[i] = 1'b1;
                else if (oclr) novr[i] = 1'b0;
                else novr[i] = m_ovr[i];
            end
            m_cap = ncap;
            m_ovr = novr;
            if (wr && a == 3'd1) m_rise = wd[3:0];
            if (wr && a == 3'd2) m_mask = wd[3:0];
            if (wr && a == 3'd4) m_fall = wd[3:0];
            in_q.push_front(inp);
            void'(in_q.pop_back());
        end
        m_irq = |(m_cap & m_mask);
    endtask

    // One clock: drive at negedge, model at posedge, compare at the following negedge.
    task automatic step(input logic r, input logic [3:0] inp, input logic cs, input logic wn,
                        input logic [2:0] a, input logic [31:0] wd);
        reset = r; in_port = inp; chipselect = cs; write_n = wn; address = a; writedata = wd;
        @(posedge clk);
        model_edge(r, inp, cs, wn, a, wd);
        @(negedge clk);
        chk("readdata", readdata, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input logic [3:0] inp, input logic [2:0] a);
        step(1'b0, inp, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic wr_reg(input logic [3:0] inp, input logic [2:0] a, input logic [31:0] wd);
        step(1'b0, inp, 1'b1, 1'b0, a, wd);
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 32'd0);
        step(1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // Rise on bit 0 lands in edge_capture after LAT edges; addr 3 reads it back one cycle later.
        for (int k = 1; k <= LAT + 1; k++) begin
            idle(4'h1, 3'd3);
            if (k == LAT) chk("cap_before_latency", readdata, 32'd0);
            if (k == LAT + 1) chk("cap_after_latency", readdata, 32'd1);
        end
        chk("irq_masked", {31'd0, irq}, 32'd0);
        wr_reg(4'h1, 3'd2, 32'h1);
        chk("irq_unmasked", {31'd0, irq}, 32'd1);

        // Fall-only enable on bit 1.
        step(1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 32'd0);
        wr_reg(4'h0, 3'd4, 32'h2);
        wr_reg(4'h0, 3'd1, 32'h0);
        repeat (5) idle(4'h2, 3'd3);
        repeat (LAT + 1) idle(4'h0, 3'd3);
        chk("fall_capture", readdata, 32'h2);

        // Overrun on bit 0 and W1C of both registers.
        step(1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 32'd0);
        wr_reg(4'h0, 3'd2, 32'h1);
        repeat (2) idle(4'h1, 3'd3);
        repeat (2) idle(4'h0, 3'd3);
        repeat (2) idle(4'h1, 3'd3);
        repeat (LAT) idle(4'h1, 3'd5);
        chk("overrun_set", readdata, 32'h1);
        wr_reg(4'h1, 3'd5, 32'h1);
        idle(4'h1, 3'd5);
        chk("overrun_clr", readdata, 32'h0);
        wr_reg(4'h1, 3'd3, 32'h1);
        idle(4'h1, 3'd3);
        chk("cap_clr", readdata, 32'h0);
        chk("irq_after_clr", {31'd0, irq}, 32'd0);

        // Clear of edge_capture[2] coinciding with a new bit-2 event.
        step(1'b1, 4'h0, 1'b0, 1'b1, 3'd0, 32'd0);
        repeat (LAT + 1) idle(4'h4, 3'd3);
        repeat (2) idle(4'h0, 3'd3);
        idle(4'h4, 3'd3);
        repeat (LAT - 2) idle(4'h4, 3'd3);
        wr_reg(4'h4, 3'd3, 32'h4);
        idle(4'h4, 3'd3);
        chk("set_wins_cap", readdata, 32'h4);
        idle(4'h4, 3'd5);
        chk("set_wins_ovr", readdata, 32'h0);

        // Unmapped and data reads, then reset overriding a write.
        repeat (LAT + 1) idle(4'hF, 3'd6);
        chk("read_addr6", readdata, 32'h0);
        idle(4'hF, 3'd0);
        chk("read_data", readdata, 32'hF);
        wr_reg(4'hF, 3'd2, 32'hF);
        step(1'b1, 4'hF, 1'b1, 1'b0, 3'd2, 32'hF);
        idle(4'hF, 3'd2);
        chk("reset_mask", readdata, 32'h0);
        idle(4'hF, 3'd1);
        chk("reset_rise", readdata, 32'hF);
        idle(4'hF, 3'd4);
        chk("reset_fall", readdata, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic r, cs, wn;
            r  = ($urandom_range(0, 99) < 2);
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) != 0);
            step(r, 4'($urandom), cs, wn, 3'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
